// File: rtl/dmem_arbiter.sv
// Single-port data-memory arbiter between the core MA stage (port C) and an
// external requester (port X), with starvation forcing and bounded X lock.
module dmem_arbiter #(
  parameter int unsigned AW       = 32,
  parameter int unsigned DW       = 32,
  parameter int unsigned MAX_WAIT = 4,
  parameter int unsigned MAX_LOCK = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          c_req,
  input  logic          c_we,
  input  logic [AW-1:0] c_addr,
  input  logic [DW-1:0] c_wd,
  output logic [DW-1:0] c_rdata,
  output logic          c_stall,
  input  logic          x_req,
  input  logic          x_we,
  input  logic          x_lock,
  input  logic [AW-1:0] x_addr,
  input  logic [DW-1:0] x_wd,
  output logic          x_gnt,
  output logic          x_rvalid,
  output logic [DW-1:0] x_rdata,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wd,
  input  logic [DW-1:0] mem_rd
);

  localparam int unsigned WCW = $clog2(MAX_WAIT + 1);
  localparam int unsigned LCW = $clog2(MAX_LOCK + 1);

  typedef enum logic [1:0] {
    S_ARB     = 2'd0,
    S_XLOCK   = 2'd1,
    S_RELEASE = 2'd2
  } state_t;

  state_t         state, state_nxt;
  logic [WCW-1:0] wait_cnt, wait_nxt;
  logic [LCW-1:0] lock_cnt, lock_nxt;
  logic           gnt_c, gnt_x, force_x;

  assign force_x = x_req && (wait_cnt == WCW'(MAX_WAIT));

  // State, counters and registered X read return
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_ARB;
      wait_cnt <= '0;
      lock_cnt <= '0;
      x_rvalid <= 1'b0;
      x_rdata  <= '0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= wait_nxt;
      lock_cnt <= lock_nxt;
      x_rvalid <= gnt_x && !x_we;
      if (gnt_x && !x_we) x_rdata <= mem_rd;
    end
  end

  // Grant decision and next state
  always_comb begin
    gnt_x     = 1'b0;
    gnt_c     = 1'b0;
    state_nxt = state;
    lock_nxt  = lock_cnt;
    case (state)
      S_ARB: begin
        gnt_x = x_req && (!c_req || force_x);
        gnt_c = c_req && !gnt_x;
        if (gnt_x && x_lock) begin
          state_nxt = S_XLOCK;
          lock_nxt  = LCW'(1);
        end
      end
      S_XLOCK: begin
        gnt_x = x_req;
        gnt_c = c_req && !x_req;
        if (gnt_x) lock_nxt = lock_cnt + LCW'(1);
        if (gnt_x && x_lock && (lock_cnt + LCW'(1) == LCW'(MAX_LOCK)))
          state_nxt = S_RELEASE;
        else if (gnt_x && x_lock)
          state_nxt = S_XLOCK;
        else
          state_nxt = S_ARB;
      end
      S_RELEASE: begin
        gnt_c     = c_req;
        state_nxt = S_ARB;
      end
      default: state_nxt = S_ARB;
    endcase
  end

  // Starvation counter saturates so force_x stays asserted until X wins
  always_comb begin
    wait_nxt = wait_cnt;
    if (gnt_x || !x_req)
      wait_nxt = '0;
    else if (wait_cnt != WCW'(MAX_WAIT))
      wait_nxt = wait_cnt + WCW'(1);
  end

  // Memory mux: idle bus drives zeros
  always_comb begin
    mem_we   = 1'b0;
    mem_addr = '0;
    mem_wd   = '0;
    if (gnt_x) begin
      mem_we   = x_we;
      mem_addr = x_addr;
      mem_wd   = x_wd;
    end else if (gnt_c) begin
      mem_we   = c_we;
      mem_addr = c_addr;
      mem_wd   = c_wd;
    end
  end

  assign c_rdata = mem_rd;
  assign c_stall = c_req && !gnt_c;
  assign x_gnt   = gnt_x;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed self-checking bench for dmem_arbiter with a small behavioural memory.
module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        c_req, c_we;
  logic [31:0] c_addr, c_wd, c_rdata;
  logic        c_stall;
  logic        x_req, x_we, x_lock;
  logic [31:0] x_addr, x_wd;
  logic        x_gnt, x_rvalid;
  logic [31:0] x_rdata;
  logic        mem_we;
  logic [31:0] mem_addr, mem_wd, mem_rd;

  logic [31:0] mem [0:255];
  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  dmem_arbiter #(.AW(32), .DW(32), .MAX_WAIT(4), .MAX_LOCK(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .c_req(c_req), .c_we(c_we), .c_addr(c_addr), .c_wd(c_wd),
    .c_rdata(c_rdata), .c_stall(c_stall),
    .x_req(x_req), .x_we(x_we), .x_lock(x_lock), .x_addr(x_addr), .x_wd(x_wd),
    .x_gnt(x_gnt), .x_rvalid(x_rvalid), .x_rdata(x_rdata),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wd(mem_wd), .mem_rd(mem_rd)
  );

  assign mem_rd = mem[mem_addr[9:2]];
  always @(posedge clk) if (mem_we) mem[mem_addr[9:2]] <= mem_wd;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    c_req = 1'b0; c_we = 1'b0; c_addr = '0; c_wd = '0;
    x_req = 1'b0; x_we = 1'b0; x_lock = 1'b0; x_addr = '0; x_wd = '0;
  endtask

  task automatic test_reset();
    idle();
    rst_n = 1'b0;
    c_req = 1'b1; x_req = 1'b1; c_addr = 32'h40;
    @(negedge clk);
    n_vec++; if (c_stall !== 1'b0) begin n_err++; $display("FAIL reset_c_stall got %b exp 0", c_stall); end
    n_vec++; if (x_gnt !== 1'b0) begin n_err++; $display("FAIL reset_x_gnt got %b exp 0", x_gnt); end
    n_vec++; if (x_rvalid !== 1'b0) begin n_err++; $display("FAIL reset_x_rvalid got %b exp 0", x_rvalid); end
    n_vec++; if (x_rdata !== 32'h0) begin n_err++; $display("FAIL reset_x_rdata got %h exp 0", x_rdata); end
    idle();
    tick();
    rst_n = 1'b1;
    @(negedge clk);
    n_vec++; if (mem_we !== 1'b0 || mem_addr !== 32'h0 || mem_wd !== 32'h0) begin
      n_err++; $display("FAIL idle_mux got we=%b a=%h d=%h exp 0/0/0", mem_we, mem_addr, mem_wd);
    end
    tick();
  endtask

  task automatic test_core_only();
    for (int i = 0; i < 10; i++) begin
      c_req = 1'b1; c_we = (i % 2 == 0); c_addr = 32'h40; c_wd = 32'hDEADBEEF;
      @(negedge clk);
      n_vec++; if (c_stall !== 1'b0) begin n_err++; $display("FAIL core_stall[%0d] got %b exp 0", i, c_stall); end
      if (c_we) begin
        n_vec++; if (mem_we !== 1'b1 || mem_addr !== 32'h40 || mem_wd !== 32'hDEADBEEF) begin
          n_err++; $display("FAIL core_store[%0d] got we=%b a=%h d=%h exp 1/40/deadbeef", i, mem_we, mem_addr, mem_wd);
        end
      end else begin
        n_vec++; if (c_rdata !== 32'hDEADBEEF) begin n_err++; $display("FAIL core_load[%0d] got %h exp deadbeef", i, c_rdata); end
      end
      tick();
    end
    idle();
    tick();
  endtask

  task automatic test_x_only();
    x_req = 1'b1; x_we = 1'b1; x_addr = 32'h80; x_wd = 32'h12345678;
    @(negedge clk);
    n_vec++; if (x_gnt !== 1'b1) begin n_err++; $display("FAIL x_wr_gnt got %b exp 1", x_gnt); end
    n_vec++; if (mem_we !== 1'b1 || mem_addr !== 32'h80 || mem_wd !== 32'h12345678) begin
      n_err++; $display("FAIL x_wr_mux got we=%b a=%h d=%h exp 1/80/12345678", mem_we, mem_addr, mem_wd);
    end
    tick();
    x_we = 1'b0; x_wd = '0;
    @(negedge clk);
    n_vec++; if (x_gnt !== 1'b1) begin n_err++; $display("FAIL x_rd_gnt got %b exp 1", x_gnt); end
    n_vec++; if (x_rvalid !== 1'b0) begin n_err++; $display("FAIL x_rvalid_after_wr got %b exp 0", x_rvalid); end
    tick();
    idle();
    @(negedge clk);
    n_vec++; if (x_rvalid !== 1'b1) begin n_err++; $display("FAIL x_rvalid got %b exp 1", x_rvalid); end
    n_vec++; if (x_rdata !== 32'h12345678) begin n_err++; $display("FAIL x_rdata got %h exp 12345678", x_rdata); end
    tick();
    @(negedge clk);
    n_vec++; if (x_rvalid !== 1'b0) begin n_err++; $display("FAIL x_rvalid_pulse got %b exp 0", x_rvalid); end
    n_vec++; if (x_rdata !== 32'h12345678) begin n_err++; $display("FAIL x_rdata_hold got %h exp 12345678", x_rdata); end
    tick();
  endtask

  // Core requests every cycle; X wins on cycles 4 and 9 (counter restarts after grant)
  task automatic test_starvation();
    c_req = 1'b1; c_we = 1'b0; c_addr = 32'h40;
    x_req = 1'b1; x_we = 1'b0; x_addr = 32'h80;
    for (int cyc = 0; cyc < 10; cyc++) begin
      logic exp_g;
      exp_g = (cyc == 4) || (cyc == 9);
      @(negedge clk);
      n_vec++; if (x_gnt !== exp_g) begin n_err++; $display("FAIL starve_x_gnt[%0d] got %b exp %b", cyc, x_gnt, exp_g); end
      n_vec++; if (c_stall !== exp_g) begin n_err++; $display("FAIL starve_c_stall[%0d] got %b exp %b", cyc, c_stall, exp_g); end
      if (cyc == 5) begin
        n_vec++; if (x_rvalid !== 1'b1 || x_rdata !== 32'h12345678) begin
          n_err++; $display("FAIL starve_rd got v=%b d=%h exp 1/12345678", x_rvalid, x_rdata);
        end
      end
      tick();
    end
    idle();
    tick();
  endtask

  // 4 denied, 8 locked grants, release, then starvation restarts from 1
  task automatic test_lock();
    c_req = 1'b1; c_we = 1'b0; c_addr = 32'h40;
    x_req = 1'b1; x_lock = 1'b1; x_we = 1'b1; x_addr = 32'h100; x_wd = 32'hA5A5A5A5;
    for (int cyc = 0; cyc < 17; cyc++) begin
      logic exp_g;
      exp_g = (cyc >= 4 && cyc <= 11) || (cyc == 16);
      @(negedge clk);
      n_vec++; if (x_gnt !== exp_g) begin n_err++; $display("FAIL lock_x_gnt[%0d] got %b exp %b", cyc, x_gnt, exp_g); end
      n_vec++; if (c_stall !== exp_g) begin n_err++; $display("FAIL lock_c_stall[%0d] got %b exp %b", cyc, c_stall, exp_g); end
      tick();
    end
    idle();
    tick();
    tick();
  endtask

  task automatic test_lock_early_exit();
    x_req = 1'b1; x_lock = 1'b1; x_we = 1'b1; x_addr = 32'h104; x_wd = 32'h11;
    for (int cyc = 0; cyc < 5; cyc++) begin
      logic exp_g, exp_s;
      c_req  = (cyc != 0);
      x_lock = (cyc < 3);
      exp_g  = (cyc < 4);
      exp_s  = (cyc >= 1 && cyc < 4);
      @(negedge clk);
      n_vec++; if (x_gnt !== exp_g) begin n_err++; $display("FAIL early_x_gnt[%0d] got %b exp %b", cyc, x_gnt, exp_g); end
      n_vec++; if (c_stall !== exp_s) begin n_err++; $display("FAIL early_c_stall[%0d] got %b exp %b", cyc, c_stall, exp_s); end
      tick();
    end
    idle();
    tick();
  endtask

  task automatic test_async_reset();
    x_req = 1'b1; x_lock = 1'b1; x_we = 1'b0; x_addr = 32'h80;
    @(negedge clk);
    n_vec++; if (x_gnt !== 1'b1) begin n_err++; $display("FAIL ar_gnt got %b exp 1", x_gnt); end
    tick();
    c_req = 1'b1; c_addr = 32'h40;
    #1;
    n_vec++; if (x_rvalid !== 1'b1 || x_gnt !== 1'b1) begin
      n_err++; $display("FAIL ar_pre got v=%b g=%b exp 1/1", x_rvalid, x_gnt);
    end
    rst_n = 1'b0;
    #1;
    n_vec++; if (x_rvalid !== 1'b0) begin n_err++; $display("FAIL ar_rvalid got %b exp 0", x_rvalid); end
    n_vec++; if (x_rdata !== 32'h0) begin n_err++; $display("FAIL ar_rdata got %h exp 0", x_rdata); end
    n_vec++; if (x_gnt !== 1'b0 || c_stall !== 1'b0) begin
      n_err++; $display("FAIL ar_state got g=%b s=%b exp 0/0", x_gnt, c_stall);
    end
    idle();
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = '0;
    idle();
    rst_n = 1'b0;
    test_reset();
    test_core_only();
    test_x_only();
    test_starvation();
    test_lock();
    test_lock_early_exit();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout got running exp finished");
    $fatal(1, "timeout");
  end

endmodule
